// File: rtl/down_timer.sv
// Programmable down-counting timer: loads a start value, counts down to zero at a
// prescaled rate, pulses tc at terminal count and optionally auto-reloads.
module down_timer #(
    parameter int unsigned N  = 8,
    parameter int unsigned PW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [N-1:0]  load_value,
    input  logic          start,
    input  logic          stop,
    input  logic          auto_reload,
    input  logic [PW-1:0] prescale,
    output logic [N-1:0]  count,
    output logic          busy,
    output logic          tc,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [N-1:0]   reload_reg;
    logic [PW-1:0]  prescale_reg;
    logic [PW-1:0]  pre;

    logic [N-1:0]   eff_count_c;
    logic           tick_c;

    // Value a start would count from: a same-cycle load wins over the held count.
    assign eff_count_c = load ? load_value : count;

    // Prescaler terminal: one decrement opportunity every prescale_reg+1 cycles.
    assign tick_c = (pre == prescale_reg);

    // Timer state machine with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            count        <= '0;
            reload_reg   <= '0;
            prescale_reg <= '0;
            pre          <= '0;
            busy         <= 1'b0;
            tc           <= 1'b0;
            done         <= 1'b0;
        end else begin
            tc <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start && (eff_count_c != '0)) begin
                        if (load) begin
                            reload_reg <= load_value;
                        end
                        count        <= eff_count_c;
                        prescale_reg <= prescale;
                        pre          <= '0;
                        state        <= RUN;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                    end else if (load) begin
                        count      <= load_value;
                        reload_reg <= load_value;
                        state      <= IDLE;
                        done       <= 1'b0;
                    end
                end

                RUN: begin
                    if (stop) begin
                        // Abort wins over a coinciding terminal tick; count is held.
                        pre   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (tick_c) begin
                        pre <= '0;
                        if (count > N'(1)) begin
                            count <= count - N'(1);
                        end else begin
                            tc <= 1'b1;
                            if (auto_reload && (reload_reg != '0)) begin
                                count <= reload_reg;
                            end else begin
                                count <= '0;
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end else begin
                        pre <= pre + PW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer: stimulus pushes expected outputs computed from
// elapsed-cycle arithmetic; a monitor pops and compares after every clock edge.
module tb_down_timer;

    localparam int unsigned N  = 8;
    localparam int unsigned PW = 4;

    logic          clk;
    logic          reset_n;
    logic          load;
    logic [N-1:0]  load_value;
    logic          start;
    logic          stop;
    logic          auto_reload;
    logic [PW-1:0] prescale;
    logic [N-1:0]  count;
    logic          busy;
    logic          tc;
    logic          done;

    down_timer #(.N(N), .PW(PW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load),
        .load_value  (load_value),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .prescale    (prescale),
        .count       (count),
        .busy        (busy),
        .tc          (tc),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int tag;
        int count;
        bit busy;
        bit tc;
        bit done;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: 0 idle, 1 run, 2 done. While running, the count is derived
    // from the number of edges since the segment began.
    int m_mode, m_count, m_reload, m_p, seg_count, seg_start, cyc, tag;

    task automatic model_reset();
        m_mode = 0; m_count = 0; m_reload = 0; m_p = 0;
        seg_count = 0; seg_start = 0; cyc = 0;
    endtask

    task automatic step(input bit ld, input int lv, input bit st, input bit sp,
                        input bit ar, input int ps);
        exp_t e;
        int   eff;
        int   t;
        bit   e_tc;
        @(negedge clk);
        load        = ld;
        load_value  = N'(lv);
        start       = st;
        stop        = sp;
        auto_reload = ar;
        prescale    = PW'(ps);
        cyc++;
        e_tc = 1'b0;
        if (m_mode == 1) begin
            t = cyc - seg_start;
            if (sp) begin
                m_count = seg_count - (t - 1) / (m_p + 1);
                m_mode  = 0;
            end else if (t == seg_count * (m_p + 1)) begin
                e_tc = 1'b1;
                if (ar && m_reload != 0) begin
                    seg_count = m_reload;
                    seg_start = cyc;
                    m_count   = m_reload;
                end else begin
                    m_count = 0;
                    m_mode  = 2;
                end
            end else begin
                m_count = seg_count - t / (m_p + 1);
            end
        end else begin
            eff = ld ? lv : m_count;
            if (st && eff != 0) begin
                if (ld) m_reload = lv;
                m_count   = eff;
                seg_count = eff;
                seg_start = cyc;
                m_p       = ps;
                m_mode    = 1;
            end else if (ld) begin
                m_count  = lv;
                m_reload = lv;
                m_mode   = 0;
            end
        end
        tag++;
        e.tag   = tag;
        e.count = m_count;
        e.busy  = (m_mode == 1);
        e.tc    = e_tc;
        e.done  = (m_mode == 2);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle_ar(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 0);
    endtask

    task automatic check_direct(input string name, input int c, input bit b,
                                input bit t, input bit d);
        total++;
        if (int'(count) != c || busy !== b || tc !== t || done !== d) begin
            bad++;
            $display("FAIL %s: got count=%0d busy=%0b tc=%0b done=%0b, want count=%0d busy=%0b tc=%0b done=%0b",
                     name, count, busy, tc, done, c, b, t, d);
        end
    endtask

    // Monitor: compare DUT outputs against the next expected entry after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (int'(count) != e.count || busy !== e.busy || tc !== e.tc || done !== e.done) begin
                    bad++;
                    $display("FAIL step%0d: got count=%0d busy=%0b tc=%0b done=%0b, want count=%0d busy=%0b tc=%0b done=%0b",
                             e.tag, count, busy, tc, done, e.count, e.busy, e.tc, e.done);
                end
            end
        end
    end

    initial begin
        int ar_r;
        tag = 0;
        model_reset();
        reset_n = 1'b0; load = 0; load_value = '0; start = 0; stop = 0;
        auto_reload = 0; prescale = '0;
        repeat (2) @(posedge clk);
        #1;
        check_direct("reset_state", 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // One-shot, prescale 0.
        step(1, 3, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        idle(5);

        // Prescaled countdown.
        step(1, 2, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 3);
        idle(10);

        // Auto-reload, then clear it.
        step(1, 4, 0, 0, 1, 0);
        step(0, 0, 1, 0, 1, 0);
        idle_ar(10);
        idle(6);

        // Stop after two ticks, resume, then zero start.
        step(1, 6, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 1, 0, 0);
        idle(2);
        step(0, 0, 1, 0, 0, 0);
        idle(6);
        step(0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        idle(2);

        // Load + start together, load ignored in RUN.
        step(1, 7, 1, 0, 0, 0);
        step(1, 9, 0, 0, 0, 0);
        idle(8);

        // Stop coinciding with the terminal tick.
        step(1, 2, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(2);

        // Asynchronous reset mid-RUN.
        step(1, 5, 1, 0, 0, 0);
        idle(2);
        @(posedge clk);
        #3;
        load = 0; start = 0; stop = 0; auto_reload = 0; prescale = '0; load_value = '0;
        reset_n = 1'b0;
        #1;
        check_direct("async_reset", 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);
        check_direct("after_reset_release", 0, 0, 0, 0);

        // Randomized traffic.
        ar_r = 0;
        for (int i = 0; i < 1500; i++) begin
            bit ld, st, sp;
            int lv;
            if ($urandom % 32 == 0) ar_r = 1 - ar_r;
            ld = ($urandom % 8 == 0);
            st = ($urandom % 6 == 0);
            sp = ($urandom % 20 == 0);
            lv = ($urandom % 8 == 0) ? int'($urandom_range(0, 20)) : int'($urandom % 6);
            step(ld, lv, st, sp, bit'(ar_r), int'($urandom % 4));
        end
        idle(3);

        repeat (2) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Programmable down-counting timer; the decrementing counterpart to the team's free-running up counter.
- Loads a start value, counts down to zero at a prescaled rate, and flags terminal count.
- Optionally auto-reloads the last loaded value for periodic ticks.
- Used for timeouts, delay generation and periodic event strobes in lab designs.

Parameters:
- N, 8, counter and load-value width in bits.
- PW, 4, prescaler width in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  reset.
- load  input  1  capture load_value into count and reload register.
- load_value  input  N  value captured on load.
- start  input  1  begin counting from current count.
- stop  input  1  abort counting; count is held.
- auto_reload  input  1  1 = reload and continue at terminal count; 0 = one-shot.
- prescale  input  PW  decrement every prescale+1 cycles; sampled on start.
- count  output  N  current counter value.
- busy  output  1  high while in RUN.
- tc  output  1  one-cycle terminal-count pulse.
- done  output  1  one-shot completion flag, held high until next load or start.

Behaviour:
- Reset: reset_n is asynchronous, active-low. Asserting it clears immediately: count=0, reload_reg=0, prescale_reg=0, prescaler counter pre=0, state=IDLE, busy=0, tc=0, done=0. Applies mid-RUN too; no residual pulse after release.
- States: IDLE, RUN, DONE. busy=1 only in RUN. done=1 only in DONE. All outputs registered.
- load, accepted in IDLE or DONE only (ignored in RUN):
  - count<=load_value, reload_reg<=load_value.
  - DONE->IDLE, done cleared.
- start, accepted in IDLE or DONE:
  - If the effective count is nonzero: ->RUN, prescale_reg<=prescale, pre<=0, done cleared.
  - Effective count = load_value if load is asserted the same cycle, else count. load and start together start from load_value.
  - If the effective count is zero: start is ignored and state is unchanged.
- RUN, tick generation: tick = (pre==prescale_reg). pre increments each cycle and wraps to 0 on tick. With prescale_reg=0, a tick occurs every cycle.
- RUN, tick with count>1: count<=count-1.
- RUN, tick with count==1 (terminal):
  - tc<=1 for exactly one cycle.
  - auto_reload=1 and reload_reg!=0: count<=reload_reg, stay RUN.
  - Otherwise: count<=0, ->DONE, done<=1.
- Timing:
  - First decrement occurs prescale_reg+1 edges after the start edge.
  - One-shot duration = count*(prescale_reg+1) cycles from start edge to the tc edge.
  - Auto-reload period = reload_reg*(prescale_reg+1) cycles.
- stop in RUN: ->IDLE, count held, pre<=0, no tc. stop has priority over a same-cycle terminal tick and over start. stop outside RUN has no effect.
- Arithmetic: unsigned N-bit. count never underflows, because 0 is never decremented.
- auto_reload is sampled at each terminal tick. Clearing it mid-run makes the current period the last.

Test Plan:
- Reset mid-RUN: count=5, start, drop reset_n mid-cycle -> count=0, busy=0, tc=0 immediately, with no clock edge needed.
- One-shot: load 3, prescale=0, start -> count 3,2,1,0 on successive edges; tc and done rise with count=0, 3 cycles after start; busy falls on the same edge.
- Prescale: load 2, prescale=3, start -> decrements every 4 cycles; tc 8 cycles after start.
- Auto-reload: load 4, prescale=0, auto_reload=1, start -> tc every 4 cycles, count sequence 4,3,2,1,4,3,...; clear auto_reload -> next terminal goes to DONE, count=0.
- Stop and zero start:
  - count=6, stop after 2 ticks -> IDLE, count=4 held.
  - start again -> resumes from 4.
  - start with count=0 -> stays IDLE, busy=0.
- Simultaneous events:
  - load 7 + start same cycle -> RUN with count=7.
  - stop coinciding with the terminal tick -> IDLE, count=1, tc=0.
  - load during RUN -> ignored.
